// File: rtl/lifo_pkg.sv
// -----------------------------------------------------------------------------
// lifo_pkg
// Shared types and default sizes for the LIFO port controller slice.
//   lifo_ctrl_state_t : read-path FSM states (IDLE, POP, CAPT, HOLD)
//   LIFO_WIDTH        : default data width
//   LIFO_DEPTH        : default stack depth
// -----------------------------------------------------------------------------
package lifo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        CAPT = 2'd2,
        HOLD = 2'd3
    } lifo_ctrl_state_t;

    localparam int LIFO_WIDTH = 8;
    localparam int LIFO_DEPTH = 8;

endpackage

// File: rtl/lifo_port_ctrl_if.sv
// -----------------------------------------------------------------------------
// lifo_port_ctrl_if
// Stream-side handshake bundle of the LIFO port controller.
//   wr_*     : valid/ready write stream (payload in wr_data)
//   rd_req_* : valid/ready read-request channel (no payload)
//   rd_rsp_* : valid/ready read-response channel carrying the popped word
// Modports:
//   master : client side (offers writes/requests, consumes responses)
//   slave  : controller side
// -----------------------------------------------------------------------------
interface lifo_port_ctrl_if
    import lifo_pkg::*;
#(
    parameter int WIDTH = LIFO_WIDTH
);

    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic             rd_req_valid;
    logic             rd_req_ready;
    logic             rd_rsp_valid;
    logic             rd_rsp_ready;
    logic [WIDTH-1:0] rd_rsp_data;

    modport master (
        output wr_valid, wr_data, rd_req_valid, rd_rsp_ready,
        input  wr_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data
    );

    modport slave (
        input  wr_valid, wr_data, rd_req_valid, rd_rsp_ready,
        output wr_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data
    );

endinterface

// File: rtl/lifo_port_ctrl.sv
// -----------------------------------------------------------------------------
// lifo_port_ctrl
// Sole driver of the attached lifo stack's push/pop pins. Turns a write stream
// and a read-request channel into mutually exclusive single-cycle push/pop
// strobes, captures the stack's registered dout into a held response register,
// and keeps its own occupancy count, flagging any disagreement with the
// stack's empty/full flags.
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   bus        : slave side of lifo_port_ctrl_if (wr_*, rd_req_*, rd_rsp_*)
//   lifo_push  : push strobe to the stack
//   lifo_pop   : pop strobe to the stack
//   lifo_din   : stack write data (mirrors bus.wr_data)
//   lifo_dout  : stack registered read data
//   lifo_empty : stack empty flag
//   lifo_full  : stack full flag
//   level      : controller occupancy, 0..DEPTH
//   sync_err   : sticky flag, level disagrees with the stack flags
// -----------------------------------------------------------------------------
module lifo_port_ctrl
    import lifo_pkg::*;
#(
    parameter int WIDTH = LIFO_WIDTH,
    parameter int DEPTH = LIFO_DEPTH,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    lifo_port_ctrl_if.slave       bus,
    output logic                  lifo_push,
    output logic                  lifo_pop,
    output logic [WIDTH-1:0]      lifo_din,
    input  logic [WIDTH-1:0]      lifo_dout,
    input  logic                  lifo_empty,
    input  logic                  lifo_full,
    output logic [LW-1:0]         level,
    output logic                  sync_err
);

    localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

    lifo_ctrl_state_t state, state_nxt;

    logic             rd_ready_c;
    logic             wr_ready_c;
    logic             rd_acc;
    logic             wr_acc;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_data_q;

    // Next state and accept logic. Readies are gated by rst so no strobe can
    // leak out while the stack is being cleared alongside us.
    always_comb begin
        state_nxt  = state;
        rd_ready_c = 1'b0;
        wr_ready_c = 1'b0;
        unique case (state)
            IDLE: begin
                rd_ready_c = !lifo_empty && !rst;
                // Reads win: a write is refused in the cycle a read is taken.
                wr_ready_c = !lifo_full && !rst && !(bus.rd_req_valid && rd_ready_c);
                if (bus.rd_req_valid && rd_ready_c) begin
                    state_nxt = POP;
                end
            end
            POP:        state_nxt = CAPT;
            CAPT, HOLD: state_nxt = bus.rd_rsp_ready ? IDLE : HOLD;
            default:    state_nxt = IDLE;
        endcase
    end

    assign rd_acc = bus.rd_req_valid && rd_ready_c;
    assign wr_acc = bus.wr_valid && wr_ready_c;

    assign lifo_pop         = rd_acc;
    assign lifo_push        = wr_acc;
    assign lifo_din         = bus.wr_data;
    assign bus.rd_req_ready = rd_ready_c;
    assign bus.wr_ready     = wr_ready_c;
    assign bus.rd_rsp_valid = rsp_valid_q;
    assign bus.rd_rsp_data  = rsp_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stack dout becomes valid at the end of the pop cycle, so the response
    // register samples it while we sit in POP; valid is registered from the
    // next state so it is high exactly in CAPT and HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= (state_nxt == CAPT) || (state_nxt == HOLD);
            if (state == POP) begin
                rsp_data_q <= lifo_dout;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else if (wr_acc && level != LVL_MAX) begin
            level <= level + LW'(1);
        end else if (rd_acc && level != '0) begin
            level <= level - LW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_err <= 1'b0;
        end else if (((level == '0) != lifo_empty) || ((level == LVL_MAX) != lifo_full)) begin
            sync_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lifo_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lifo_port_ctrl
// Self-checking bench for lifo_port_ctrl. A behavioural stack stands in for
// the attached lifo; a queue-based transaction model predicts the controller.
// -----------------------------------------------------------------------------
module tb_lifo_port_ctrl;
    import lifo_pkg::*;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int LW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          stk_rst;
    logic          lifo_push, lifo_pop;
    logic [W-1:0]  lifo_din, lifo_dout;
    logic          lifo_empty, lifo_full;
    logic [LW-1:0] level;
    logic          sync_err;

    int checks   = 0;
    int failures = 0;

    lifo_port_ctrl_if #(.WIDTH(W)) bus ();

    lifo_port_ctrl #(.WIDTH(W), .DEPTH(D), .LW(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .lifo_push  (lifo_push),
        .lifo_pop   (lifo_pop),
        .lifo_din   (lifo_din),
        .lifo_dout  (lifo_dout),
        .lifo_empty (lifo_empty),
        .lifo_full  (lifo_full),
        .level      (level),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    // Attached stack: push updates the index at the edge, pop registers dout.
    logic [W-1:0] smem [D];
    int unsigned  scnt;
    always @(posedge clk or posedge stk_rst) begin
        if (stk_rst) begin
            scnt      <= 0;
            lifo_dout <= '0;
        end else if (lifo_push && scnt < D) begin
            smem[scnt] <= lifo_din;
            scnt       <= scnt + 1;
        end else if (lifo_pop && scnt > 0) begin
            lifo_dout <= smem[scnt-1];
            scnt      <= scnt - 1;
        end
    end
    assign lifo_empty = (scnt == 0);
    assign lifo_full  = (scnt == D);

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_valid     = 1'b0;
        bus.wr_data      = '0;
        bus.rd_req_valid = 1'b0;
        bus.rd_rsp_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stk_rst = 1'b1;
        step(); step();
        rst = 1'b0; stk_rst = 1'b0;
    endtask

    task automatic push_word(input logic [W-1:0] d, output bit ok);
        ok = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bus.wr_ready) ok = 1'b1;
            step();
        end
        bus.wr_valid = 1'b0;
    endtask

    task automatic read_word(output logic [W-1:0] d, output int lat, output bit ok);
        ok = 1'b0; lat = 0; d = '0;
        bus.rd_req_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bus.rd_req_ready) ok = 1'b1;
            step();
        end
        bus.rd_req_valid = 1'b0;
        if (ok) begin
            ok = 1'b0;
            for (int i = 1; i <= 40 && !ok; i++) begin
                @(negedge clk);
                if (bus.rd_rsp_valid) begin
                    ok = 1'b1; lat = i; d = bus.rd_rsp_data;
                end
                step();
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.wr_valid = 1'b1; bus.rd_req_valid = 1'b1;
        rst = 1'b1; stk_rst = 1'b1;
        @(negedge clk);
        checks++; if (level !== '0) begin failures++; $display("FAIL reset_level: got %0d expected 0", level); end
        checks++; if (bus.rd_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rd_rsp_valid); end
        checks++; if (bus.rd_rsp_data !== '0) begin failures++; $display("FAIL reset_rsp_data: got %h expected 00", bus.rd_rsp_data); end
        checks++; if (sync_err !== 1'b0) begin failures++; $display("FAIL reset_sync_err: got %b expected 0", sync_err); end
        checks++; if (bus.wr_ready !== 1'b0 || lifo_push !== 1'b0) begin failures++; $display("FAIL reset_wr_gate: got ready=%b push=%b expected 0/0", bus.wr_ready, lifo_push); end
        checks++; if (bus.rd_req_ready !== 1'b0 || lifo_pop !== 1'b0) begin failures++; $display("FAIL reset_rd_gate: got ready=%b pop=%b expected 0/0", bus.rd_req_ready, lifo_pop); end
        step(); step();
        rst = 1'b0; stk_rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        checks++; if (bus.wr_ready !== 1'b1 || sync_err !== 1'b0) begin failures++; $display("FAIL reset_release: got wr_ready=%b sync_err=%b expected 1/0", bus.wr_ready, sync_err); end
        step();
    endtask

    task automatic test_seq();
        logic [W-1:0] wv [3];
        logic [W-1:0] d;
        int lat;
        bit ok;
        wv[0] = 8'h11; wv[1] = 8'h22; wv[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            push_word(wv[i], ok);
            checks++; if (!ok) begin failures++; $display("FAIL seq_push: got timeout expected accept (beat %0d)", i); end
        end
        for (int i = 0; i < 3; i++) begin
            read_word(d, lat, ok);
            checks++; if (!ok || d !== wv[2-i]) begin failures++; $display("FAIL seq_data: got %h expected %h", d, wv[2-i]); end
            checks++; if (lat != 2) begin failures++; $display("FAIL seq_latency: got %0d expected 2", lat); end
        end
        @(negedge clk);
        checks++; if (level !== '0) begin failures++; $display("FAIL seq_level: got %0d expected 0", level); end
        checks++; if (sync_err !== 1'b0) begin failures++; $display("FAIL seq_sync_err: got %b expected 0", sync_err); end
        step();
    endtask

    task automatic test_fill();
        logic [W-1:0] q [$];
        logic [W-1:0] v, d;
        int lat, hit;
        bit ok;
        d = '0;
        for (int i = 0; i < D; i++) begin
            v = W'($urandom);
            push_word(v, ok);
            q.push_back(v);
            checks++; if (!ok) begin failures++; $display("FAIL fill_push: got timeout expected accept (beat %0d)", i); end
        end
        @(negedge clk);
        checks++; if (level !== LW'(D)) begin failures++; $display("FAIL fill_level: got %0d expected %0d", level, D); end
        checks++; if (lifo_full !== 1'b1 || sync_err !== 1'b0) begin failures++; $display("FAIL fill_full: got full=%b sync_err=%b expected 1/0", lifo_full, sync_err); end
        step();
        bus.wr_valid = 1'b1; bus.wr_data = 8'hC9;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (bus.wr_ready !== 1'b0 || lifo_push !== 1'b0) begin failures++; $display("FAIL fill_stall: got ready=%b push=%b expected 0/0", bus.wr_ready, lifo_push); end
            step();
        end
        bus.rd_req_valid = 1'b1;
        @(negedge clk);
        checks++; if (bus.rd_req_ready !== 1'b1 || bus.wr_ready !== 1'b0) begin failures++; $display("FAIL fill_read_accept: got rd_ready=%b wr_ready=%b expected 1/0", bus.rd_req_ready, bus.wr_ready); end
        step();
        bus.rd_req_valid = 1'b0;
        hit = 0;
        for (int i = 1; i <= 10 && hit == 0; i++) begin
            @(negedge clk);
            if (bus.rd_rsp_valid) begin hit = i; d = bus.rd_rsp_data; end
            step();
        end
        v = q.pop_back();
        checks++; if (hit != 2) begin failures++; $display("FAIL fill_rsp_latency: got %0d expected 2", hit); end
        checks++; if (d !== v) begin failures++; $display("FAIL fill_rsp_data: got %h expected %h", d, v); end
        @(negedge clk);
        checks++; if (bus.wr_ready !== 1'b1 || lifo_push !== 1'b1) begin failures++; $display("FAIL fill_release: got ready=%b push=%b expected 1/1", bus.wr_ready, lifo_push); end
        step();
        bus.wr_valid = 1'b0;
        q.push_back(8'hC9);
        @(negedge clk);
        checks++; if (level !== LW'(D)) begin failures++; $display("FAIL fill_refill_level: got %0d expected %0d", level, D); end
        step();
        for (int i = 0; i < D; i++) begin
            read_word(d, lat, ok);
            v = q.pop_back();
            checks++; if (!ok || d !== v) begin failures++; $display("FAIL fill_drain: got %h expected %h", d, v); end
        end
        @(negedge clk);
        checks++; if (level !== '0 || lifo_empty !== 1'b1) begin failures++; $display("FAIL fill_drained: got level=%0d empty=%b expected 0/1", level, lifo_empty); end
        step();
    endtask

    task automatic test_simul();
        logic [W-1:0] d;
        int lat;
        bit ok;
        push_word(8'hA1, ok);
        push_word(8'hB2, ok);
        bus.wr_valid = 1'b1; bus.wr_data = 8'hC3; bus.rd_req_valid = 1'b1;
        @(negedge clk);
        checks++; if (bus.rd_req_ready !== 1'b1 || lifo_pop !== 1'b1) begin failures++; $display("FAIL simul_read: got ready=%b pop=%b expected 1/1", bus.rd_req_ready, lifo_pop); end
        checks++; if (bus.wr_ready !== 1'b0 || lifo_push !== 1'b0) begin failures++; $display("FAIL simul_write_blocked: got ready=%b push=%b expected 0/0", bus.wr_ready, lifo_push); end
        step();
        bus.rd_req_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL simul_pop_busy: got %b expected 0", bus.wr_ready); end
        step();
        @(negedge clk);
        checks++; if (bus.rd_rsp_valid !== 1'b1 || bus.rd_rsp_data !== 8'hB2) begin failures++; $display("FAIL simul_rsp: got v=%b d=%h expected 1/b2", bus.rd_rsp_valid, bus.rd_rsp_data); end
        checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL simul_capt_busy: got %b expected 0", bus.wr_ready); end
        step();
        @(negedge clk);
        checks++; if (bus.wr_ready !== 1'b1 || lifo_push !== 1'b1) begin failures++; $display("FAIL simul_write_lands: got ready=%b push=%b expected 1/1", bus.wr_ready, lifo_push); end
        step();
        bus.wr_valid = 1'b0;
        @(negedge clk);
        checks++; if (level !== LW'(2)) begin failures++; $display("FAIL simul_level: got %0d expected 2", level); end
        step();
        read_word(d, lat, ok);
        checks++; if (!ok || d !== 8'hC3) begin failures++; $display("FAIL simul_new_top: got %h expected c3", d); end
        read_word(d, lat, ok);
        checks++; if (!ok || d !== 8'hA1) begin failures++; $display("FAIL simul_bottom: got %h expected a1", d); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d;
        int lat;
        bit ok;
        push_word(8'h3C, ok);
        push_word(8'hA5, ok);
        bus.rd_rsp_ready = 1'b0; bus.rd_req_valid = 1'b1;
        @(negedge clk);
        checks++; if (bus.rd_req_ready !== 1'b1) begin failures++; $display("FAIL bp_accept: got %b expected 1", bus.rd_req_ready); end
        step();
        bus.wr_valid = 1'b1; bus.wr_data = 8'hEE;
        step();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (bus.rd_rsp_valid !== 1'b1 || bus.rd_rsp_data !== 8'hA5) begin failures++; $display("FAIL bp_hold_data: got v=%b d=%h expected 1/a5", bus.rd_rsp_valid, bus.rd_rsp_data); end
            checks++; if (bus.rd_req_ready || bus.wr_ready || lifo_push || lifo_pop) begin failures++; $display("FAIL bp_no_accept: got rr=%b wr=%b push=%b pop=%b expected 0000", bus.rd_req_ready, bus.wr_ready, lifo_push, lifo_pop); end
            step();
        end
        bus.rd_rsp_ready = 1'b1; bus.rd_req_valid = 1'b0; bus.wr_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.rd_rsp_valid !== 1'b1 || bus.rd_rsp_data !== 8'hA5) begin failures++; $display("FAIL bp_handshake: got v=%b d=%h expected 1/a5", bus.rd_rsp_valid, bus.rd_rsp_data); end
        step();
        @(negedge clk);
        checks++; if (bus.rd_rsp_valid !== 1'b0 || bus.rd_req_ready !== 1'b1) begin failures++; $display("FAIL bp_release: got v=%b rr=%b expected 0/1", bus.rd_rsp_valid, bus.rd_req_ready); end
        step();
        read_word(d, lat, ok);
        checks++; if (!ok || d !== 8'h3C) begin failures++; $display("FAIL bp_next: got %h expected 3c", d); end
    endtask

    task automatic test_empty_read();
        bus.rd_req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (bus.rd_req_ready !== 1'b0 || lifo_pop !== 1'b0 || bus.rd_rsp_valid !== 1'b0) begin failures++; $display("FAIL empty_read: got rr=%b pop=%b v=%b expected 0/0/0", bus.rd_req_ready, lifo_pop, bus.rd_rsp_valid); end
            step();
        end
        bus.rd_req_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] d;
        int lat;
        bit ok;
        push_word(8'h77, ok);
        bus.rd_req_valid = 1'b1;
        step();
        bus.wr_valid = 1'b1; bus.wr_data = 8'h99;
        rst = 1'b1; stk_rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.rd_rsp_valid !== 1'b0 || bus.rd_rsp_data !== '0) begin failures++; $display("FAIL rmid_rsp: got v=%b d=%h expected 0/00", bus.rd_rsp_valid, bus.rd_rsp_data); end
        checks++; if (level !== '0 || sync_err !== 1'b0) begin failures++; $display("FAIL rmid_level: got level=%0d sync_err=%b expected 0/0", level, sync_err); end
        checks++; if (bus.wr_ready || bus.rd_req_ready || lifo_push || lifo_pop) begin failures++; $display("FAIL rmid_gate: got wr=%b rr=%b push=%b pop=%b expected 0000", bus.wr_ready, bus.rd_req_ready, lifo_push, lifo_pop); end
        step();
        rst = 1'b0; stk_rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.rd_rsp_valid !== 1'b0 || sync_err !== 1'b0 || bus.wr_ready !== 1'b1) begin failures++; $display("FAIL rmid_after: got v=%b sync_err=%b wr=%b expected 0/0/1", bus.rd_rsp_valid, sync_err, bus.wr_ready); end
            step();
        end
        push_word(8'h5A, ok);
        read_word(d, lat, ok);
        checks++; if (!ok || d !== 8'h5A || lat != 2) begin failures++; $display("FAIL rmid_reuse: got %h lat=%0d expected 5a lat=2", d, lat); end
    endtask

    task automatic test_ctrl_only_reset();
        bit ok;
        push_word(8'h01, ok);
        push_word(8'h02, ok);
        push_word(8'h03, ok);
        @(negedge clk);
        checks++; if (level !== LW'(3)) begin failures++; $display("FAIL cor_level: got %0d expected 3", level); end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (sync_err !== 1'b0 || level !== '0) begin failures++; $display("FAIL cor_before: got sync_err=%b level=%0d expected 0/0", sync_err, level); end
        step();
        @(negedge clk);
        checks++; if (sync_err !== 1'b1) begin failures++; $display("FAIL cor_sync_err: got %b expected 1", sync_err); end
        step(); step(); step();
        @(negedge clk);
        checks++; if (sync_err !== 1'b1) begin failures++; $display("FAIL cor_sticky: got %b expected 1", sync_err); end
        step();
        do_reset();
        @(negedge clk);
        checks++; if (sync_err !== 1'b0) begin failures++; $display("FAIL cor_clear: got %b expected 0", sync_err); end
        step();
    endtask

    // Transaction model: a queue is the stack; a read is outstanding from
    // accept until its response handshake, and its word is visible from the
    // second cycle after accept.
    task automatic test_random();
        logic [W-1:0]  q [$];
        logic [W-1:0]  rw;
        logic [LW-1:0] e_lvl;
        bit outst, e_rrdy, e_racc, e_wrdy, e_push, e_rv;
        int age;
        do_reset();
        outst = 1'b0; age = 0; rw = '0;
        for (int n = 0; n < 600; n++) begin
            bus.wr_valid     = (n < 300) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            bus.wr_data      = W'($urandom);
            bus.rd_req_valid = ($urandom_range(4) < 2);
            bus.rd_rsp_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            e_rrdy = !outst && (q.size() > 0);
            e_racc = e_rrdy && bus.rd_req_valid;
            e_wrdy = !outst && (q.size() < D) && !e_racc;
            e_push = bus.wr_valid && e_wrdy;
            e_rv   = outst && (age >= 2);
            e_lvl  = LW'(q.size());
            checks++; if (bus.rd_req_ready !== e_rrdy || lifo_pop !== e_racc) begin failures++; $display("FAIL rnd_read: got rr=%b pop=%b expected %b/%b (cycle %0d)", bus.rd_req_ready, lifo_pop, e_rrdy, e_racc, n); end
            checks++; if (bus.wr_ready !== e_wrdy || lifo_push !== e_push) begin failures++; $display("FAIL rnd_write: got wr=%b push=%b expected %b/%b (cycle %0d)", bus.wr_ready, lifo_push, e_wrdy, e_push, n); end
            checks++; if (bus.rd_rsp_valid !== e_rv) begin failures++; $display("FAIL rnd_rsp_valid: got %b expected %b (cycle %0d)", bus.rd_rsp_valid, e_rv, n); end
            if (e_rv) begin
                checks++; if (bus.rd_rsp_data !== rw) begin failures++; $display("FAIL rnd_rsp_data: got %h expected %h (cycle %0d)", bus.rd_rsp_data, rw, n); end
            end
            checks++; if (level !== e_lvl) begin failures++; $display("FAIL rnd_level: got %0d expected %0d (cycle %0d)", level, e_lvl, n); end
            checks++; if (sync_err !== 1'b0) begin failures++; $display("FAIL rnd_sync_err: got %b expected 0 (cycle %0d)", sync_err, n); end
            if (e_push) q.push_back(bus.wr_data);
            if (e_racc) begin
                rw = q.pop_back(); outst = 1'b1; age = 1;
            end else if (outst) begin
                if (e_rv && bus.rd_rsp_ready) outst = 1'b0;
                else age++;
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_seq();
        test_fill();
        test_simul();
        test_backpressure();
        test_empty_read();
        test_reset_mid();
        test_ctrl_only_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
